// File: rtl/aes_pkg.sv
// Shared AES key-schedule definitions: key-length codes, per-length schedule
// sizes, GF(2^8) doubling and the forward S-box.
package aes_pkg;

  localparam logic [1:0] KEY_LEN_128  = 2'd0;
  localparam logic [1:0] KEY_LEN_192  = 2'd1;
  localparam logic [1:0] KEY_LEN_256  = 2'd2;
  localparam logic [1:0] KEY_LEN_RSVD = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_EXPAND = 2'd1,
    ST_DONE   = 2'd2
  } kx_state_e;

  function automatic logic [3:0] aes_nk(input logic [1:0] key_len);
    logic [3:0] nk;
    case (key_len)
      KEY_LEN_128: nk = 4'd4;
      KEY_LEN_192: nk = 4'd6;
      default:     nk = 4'd8;
    endcase
    return nk;
  endfunction

  function automatic logic [3:0] aes_nr(input logic [1:0] key_len);
    logic [3:0] nr;
    case (key_len)
      KEY_LEN_128: nr = 4'd10;
      KEY_LEN_192: nr = 4'd12;
      default:     nr = 4'd14;
    endcase
    return nr;
  endfunction

  function automatic logic [5:0] aes_words(input logic [1:0] key_len);
    logic [5:0] w;
    case (key_len)
      KEY_LEN_128: w = 6'd44;
      KEY_LEN_192: w = 6'd52;
      default:     w = 6'd60;
    endcase
    return w;
  endfunction

  function automatic int aes_max_words(input int max_key_bits);
    int w;
    if (max_key_bits <= 128) begin
      w = 44;
    end else if (max_key_bits <= 192) begin
      w = 52;
    end else begin
      w = 60;
    end
    return w;
  endfunction

  // Largest key_len code this build accepts.
  function automatic logic [1:0] aes_max_key_len(input int max_key_bits);
    logic [1:0] kl;
    if (max_key_bits <= 128) begin
      kl = KEY_LEN_128;
    end else if (max_key_bits <= 192) begin
      kl = KEY_LEN_192;
    end else begin
      kl = KEY_LEN_256;
    end
    return kl;
  endfunction

  function automatic logic [7:0] aes_xtime(input logic [7:0] b);
    logic [7:0] r;
    if (b[7]) begin
      r = {b[6:0], 1'b0} ^ 8'h1b;
    end else begin
      r = {b[6:0], 1'b0};
    end
    return r;
  endfunction

  localparam logic [2047:0] SBOX_TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  // Entry 0 sits in the top byte of the table.
  function automatic logic [7:0] aes_sbox(input logic [7:0] b);
    return SBOX_TABLE[(11'd2047 - {b, 3'b000}) -: 8];
  endfunction

endpackage

// File: rtl/aes_subword.sv
// AES SubWord: applies the forward S-box to each byte of a 32-bit word.
module aes_subword
  import aes_pkg::*;
(
  input  logic [31:0] word_in,
  output logic [31:0] word_out
);

  // Four independent byte substitutions.
  always_comb begin
    word_out = {aes_sbox(word_in[31:24]), aes_sbox(word_in[23:16]),
                aes_sbox(word_in[15:8]),  aes_sbox(word_in[7:0])};
  end

endmodule

// File: rtl/aes_key_expander.sv
// Run-time selectable AES-128/192/256 key expander with a register word file
// and a one-cycle round-key read port.
module aes_key_expander
  import aes_pkg::*;
#(
  parameter int MAX_KEY_BITS = 256
) (
  input  logic                    clk,
  input  logic                    srst_n,
  input  logic                    key_ctrl_en,
  input  logic [1:0]              key_len,
  input  logic [MAX_KEY_BITS-1:0] key,
  input  logic [3:0]              round,
  output logic [127:0]            round_key,
  output logic                    key_ready,
  output logic                    busy,
  output logic                    round_err
);

  localparam int         MAX_WORDS = aes_max_words(MAX_KEY_BITS);
  localparam int         KEY_WORDS = MAX_KEY_BITS / 32;
  localparam logic [1:0] MAX_LEN   = aes_max_key_len(MAX_KEY_BITS);

  kx_state_e    state_q, state_d;
  logic [1:0]   key_len_q, key_len_d;
  logic [5:0]   ptr_q, ptr_d;
  logic [7:0]   rcon_q, rcon_d;
  logic [2:0]   pos_q, pos_d;
  logic [31:0]  words_q [MAX_WORDS];
  logic [31:0]  words_d [MAX_WORDS];
  logic [127:0] round_key_q, round_key_d;
  logic         round_err_q, round_err_d;
  logic         key_ready_q, key_ready_d;
  logic         busy_q, busy_d;

  logic         start_s;
  logic [3:0]   nk_s;
  logic [3:0]   nr_s;
  logic [5:0]   w_last_s;
  logic [5:0]   prev_idx_s, back_idx_s;
  logic [31:0]  prev_s, back_s, rot_s, sub_in_s, sub_out_s, temp_s;
  logic         wrap_s;
  logic         rd_ok_s;
  logic [5:0]   base_s;

  aes_subword u_subword (
    .word_in  (sub_in_s),
    .word_out (sub_out_s)
  );

  // Schedule recurrence operands for the word being written this cycle.
  always_comb begin
    nk_s     = aes_nk(key_len_q);
    nr_s     = aes_nr(key_len_q);
    w_last_s = aes_words(key_len_q) - 6'd1;
    start_s  = key_ctrl_en && (key_len != KEY_LEN_RSVD) && (key_len <= MAX_LEN);
    if (state_q == ST_EXPAND) begin
      prev_idx_s = ptr_q - 6'd1;
      back_idx_s = ptr_q - {2'b00, nk_s};
    end else begin
      prev_idx_s = 6'd0;
      back_idx_s = 6'd0;
    end
    prev_s = words_q[prev_idx_s];
    back_s = words_q[back_idx_s];
    rot_s  = {prev_s[23:0], prev_s[31:24]};
    wrap_s = ({1'b0, pos_q} == (nk_s - 4'd1));
    if (pos_q == 3'd0) begin
      sub_in_s = rot_s;
      temp_s   = sub_out_s ^ {rcon_q, 24'h000000};
    end else if ((nk_s == 4'd8) && (pos_q == 3'd4)) begin
      sub_in_s = prev_s;
      temp_s   = sub_out_s;
    end else begin
      sub_in_s = prev_s;
      temp_s   = prev_s;
    end
  end

  // Control FSM and word-file update.
  always_comb begin
    state_d   = state_q;
    key_len_d = key_len_q;
    ptr_d     = ptr_q;
    rcon_d    = rcon_q;
    pos_d     = pos_q;
    words_d   = words_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start_s) begin
          state_d   = ST_EXPAND;
          key_len_d = key_len;
          ptr_d     = {2'b00, aes_nk(key_len)};
          rcon_d    = 8'h01;
          pos_d     = 3'd0;
          for (int j = 0; j < KEY_WORDS; j++) begin
            if (j < int'(aes_nk(key_len))) begin
              words_d[j] = key[MAX_KEY_BITS-1-32*j -: 32];
            end else begin
              words_d[j] = words_q[j];
            end
          end
        end else begin
          state_d = state_q;
        end
      end
      ST_EXPAND: begin
        words_d[ptr_q] = back_s ^ temp_s;
        ptr_d          = ptr_q + 6'd1;
        // rcon only moves when the position counter wraps back to 0.
        if (wrap_s) begin
          pos_d  = 3'd0;
          rcon_d = aes_xtime(rcon_q);
        end else begin
          pos_d  = pos_q + 3'd1;
          rcon_d = rcon_q;
        end
        if (ptr_q == w_last_s) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_EXPAND;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d      = (state_d == ST_EXPAND);
    key_ready_d = (state_d == ST_DONE);
  end

  // Round-key read port; base index is zeroed when the request is rejected.
  always_comb begin
    rd_ok_s = key_ready_q && (round <= nr_s);
    if (rd_ok_s) begin
      base_s      = {round, 2'b00};
      round_key_d = {words_q[base_s], words_q[base_s + 6'd1],
                     words_q[base_s + 6'd2], words_q[base_s + 6'd3]};
      round_err_d = 1'b0;
    end else begin
      base_s      = 6'd0;
      round_key_d = 128'd0;
      round_err_d = 1'b1;
    end
  end

  // Control and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!srst_n) begin
      state_q     <= ST_IDLE;
      key_len_q   <= KEY_LEN_128;
      ptr_q       <= 6'd0;
      rcon_q      <= 8'h01;
      pos_q       <= 3'd0;
      round_key_q <= 128'd0;
      round_err_q <= 1'b0;
      key_ready_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      key_len_q   <= key_len_d;
      ptr_q       <= ptr_d;
      rcon_q      <= rcon_d;
      pos_q       <= pos_d;
      round_key_q <= round_key_d;
      round_err_q <= round_err_d;
      key_ready_q <= key_ready_d;
      busy_q      <= busy_d;
    end
  end

  // Word file: contents are meaningless until a schedule completes.
  always_ff @(posedge clk) begin
    words_q <= words_d;
  end

  assign round_key = round_key_q;
  assign round_err = round_err_q;
  assign key_ready = key_ready_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_aes_key_expander.sv
// Self-checking bench for aes_key_expander: known-answer vectors, an
// independent key-schedule model and a read scoreboard.
module tb_aes_key_expander;

  logic         clk;
  logic         srst_n;
  logic         key_ctrl_en;
  logic [1:0]   key_len;
  logic [255:0] key;
  logic [3:0]   round;
  logic [127:0] round_key;
  logic         key_ready, busy, round_err;

  logic         en128;
  logic [1:0]   kl128;
  logic [127:0] k128;
  logic [3:0]   r128;
  logic [127:0] rk128;
  logic         rdy128, busy128, err128;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    string        tag;
    logic [127:0] rk;
    logic         err;
  } exp_t;
  exp_t sb_q[$];

  logic [7:0]  tb_sbox [256];
  logic [31:0] mw [60];

  aes_key_expander #(.MAX_KEY_BITS(256)) u_dut (
    .clk(clk), .srst_n(srst_n), .key_ctrl_en(key_ctrl_en), .key_len(key_len),
    .key(key), .round(round), .round_key(round_key), .key_ready(key_ready),
    .busy(busy), .round_err(round_err)
  );

  aes_key_expander #(.MAX_KEY_BITS(128)) u_dut128 (
    .clk(clk), .srst_n(srst_n), .key_ctrl_en(en128), .key_len(kl128),
    .key(k128), .round(r128), .round_key(rk128), .key_ready(rdy128),
    .busy(busy128), .round_err(err128)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = aa[7] ? ({aa[6:0], 1'b0} ^ 8'h1b) : {aa[6:0], 1'b0};
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    logic [15:0] d;
    d = {b, b} << n;
    return d[15:8];
  endfunction

  // S-box from first principles: multiplicative inverse then affine map.
  task automatic build_sbox();
    for (int a = 0; a < 256; a++) begin
      logic [7:0] inv;
      inv = 8'h00;
      for (int x = 1; x < 256; x++) begin
        if (gmul(8'(a), 8'(x)) == 8'h01) inv = 8'(x);
      end
      tb_sbox[a] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [31:0] subw(input logic [31:0] w);
    return {tb_sbox[w[31:24]], tb_sbox[w[23:16]], tb_sbox[w[15:8]], tb_sbox[w[7:0]]};
  endfunction

  task automatic model_expand(input logic [255:0] k, input int nk);
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < nk; i++) mw[i] = k[255-32*i -: 32];
    for (int i = nk; i < 4 * (nk + 7); i++) begin
      t = mw[i-1];
      if (i % nk == 0) begin
        t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h000000};
        rc = gmul(rc, 8'h02);
      end else if (nk == 8 && i % nk == 4) begin
        t = subw(t);
      end
      mw[i] = mw[i-nk] ^ t;
    end
  endtask

  function automatic logic [127:0] mrk(input int r);
    return {mw[4*r], mw[4*r+1], mw[4*r+2], mw[4*r+3]};
  endfunction

  // Request a round at this negedge; the response is due one edge later.
  task automatic rd(input int r, input logic [127:0] ek, input logic ee, input string tag);
    exp_t e;
    round = 4'(r);
    e.tag = tag;
    e.rk  = ek;
    e.err = ee;
    sb_q.push_back(e);
    @(negedge clk);
    e = sb_q.pop_front();
    check({e.tag, "_key"}, round_key, e.rk);
    check({e.tag, "_err"}, 128'(round_err), 128'(e.err));
  endtask

  task automatic start_exp(input logic [1:0] len, input logic [255:0] k, input int exp_cycles,
                           input int pulse_at, input int abort_at);
    int cnt;
    key_ctrl_en = 1'b1;
    key_len     = len;
    key         = k;
    @(negedge clk);
    key_ctrl_en = 1'b0;
    key         = ~k;
    key_len     = (len == 2'd0) ? 2'd2 : 2'd0;
    check("busy_rise", 128'(busy), 128'd1);
    check("ready_fall", 128'(key_ready), 128'd0);
    cnt = 0;
    while (key_ready !== 1'b1 && cnt < 200) begin
      if (abort_at >= 0 && cnt == abort_at) begin
        srst_n = 1'b0;
        @(negedge clk);
        srst_n = 1'b1;
        check("abort_ready", 128'(key_ready), 128'd0);
        check("abort_busy", 128'(busy), 128'd0);
        return;
      end
      key_ctrl_en = (cnt == pulse_at);
      @(negedge clk);
      cnt++;
    end
    key_ctrl_en = 1'b0;
    check("ready_cycles", 128'(cnt), 128'(exp_cycles));
    check("busy_fall", 128'(busy), 128'd0);
  endtask

  initial begin
    logic [255:0] k_fips128, k_fips192, k_fips256, k_2b7e;
    int cnt;
    k_fips128 = {128'h000102030405060708090a0b0c0d0e0f, 128'd0};
    k_fips192 = {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'd0};
    k_fips256 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    k_2b7e    = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'd0};

    build_sbox();
    srst_n = 1'b0; key_ctrl_en = 1'b0; key_len = 2'd0; key = 256'd0; round = 4'd0;
    en128 = 1'b0; kl128 = 2'd0; k128 = 128'd0; r128 = 4'd0;
    repeat (3) @(negedge clk);
    check("rst_round_key", round_key, 128'd0);
    check("rst_ready", 128'(key_ready), 128'd0);
    check("rst_busy", 128'(busy), 128'd0);
    check("rst_err", 128'(round_err), 128'd0);
    srst_n = 1'b1;
    rd(0, 128'd0, 1'b1, "not_ready");

    start_exp(2'd0, k_fips128, 40, -1, -1);
    rd(0,  128'h000102030405060708090a0b0c0d0e0f, 1'b0, "a128_r0");
    rd(10, 128'h13111d7fe3944a17f307a78b4d2b30c5, 1'b0, "a128_r10");
    rd(11, 128'd0, 1'b1, "a128_r11");

    start_exp(2'd1, k_fips192, 46, -1, -1);
    rd(1,  128'h10111213141516175846f2f95c43f4fe, 1'b0, "a192_r1");
    rd(12, 128'ha4970a331a78dc09c418c271e3a41d5d, 1'b0, "a192_r12");

    start_exp(2'd2, k_fips256, 52, -1, -1);
    rd(2,  128'ha573c29fa176c498a97fce93a572c09c, 1'b0, "a256_r2");
    rd(14, 128'h24fc79ccbf0979e9371ac23c6d68de36, 1'b0, "a256_r14");
    rd(15, 128'd0, 1'b1, "a256_r15");

    start_exp(2'd0, k_2b7e, 40, -1, -1);
    model_expand(k_2b7e, 4);
    rd(10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6, 1'b0, "fips_r10");
    for (int r = 0; r <= 10; r++) rd(r, mrk(r), 1'b0, $sformatf("sweep_r%0d", r));

    start_exp(2'd2, {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom},
              0, -1, 20);
    rd(0, 128'd0, 1'b1, "after_abort");

    start_exp(2'd0, k_2b7e, 40, 10, -1);
    for (int r = 0; r <= 10; r++) rd(r, mrk(r), 1'b0, $sformatf("pulse_r%0d", r));

    key_ctrl_en = 1'b1; key_len = 2'd3; key = k_fips256;
    @(negedge clk);
    key_ctrl_en = 1'b0;
    check("rsvd_busy", 128'(busy), 128'd0);
    check("rsvd_ready", 128'(key_ready), 128'd1);
    rd(5, mrk(5), 1'b0, "rsvd_keep_r5");

    en128 = 1'b1; kl128 = 2'd2; k128 = 128'h000102030405060708090a0b0c0d0e0f;
    @(negedge clk);
    en128 = 1'b0;
    check("m128_len2_busy", 128'(busy128), 128'd0);
    check("m128_len2_ready", 128'(rdy128), 128'd0);
    en128 = 1'b1; kl128 = 2'd0;
    @(negedge clk);
    en128 = 1'b0;
    check("m128_busy", 128'(busy128), 128'd1);
    cnt = 0;
    while (rdy128 !== 1'b1 && cnt < 200) begin
      @(negedge clk);
      cnt++;
    end
    check("m128_cycles", 128'(cnt), 128'd40);
    r128 = 4'd10;
    @(negedge clk);
    check("m128_r10", rk128, 128'h13111d7fe3944a17f307a78b4d2b30c5);
    check("m128_r10_err", 128'(err128), 128'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/aes_key_expander.md
Name: aes_key_expander

Overview:
Parametrised successor to the AES-256-only key controller. It expands a cipher key into the full round-key schedule for AES-128, AES-192 or AES-256, with the key length selected at run time. Round keys are stored in an internal word file. The block serves any round key by index with a fixed one-cycle read latency. It sits between key loading and the AES round datapath.

Parameters:
MAX_KEY_BITS, 256, largest key length supported (128, 192 or 256). Sets the key port width, the storage depth (4*(Nr_max+1) words) and which key_len codes are legal.

Ports:
clk  in  1  clock; all logic on rising edge
srst_n  in  1  synchronous active-low reset
key_ctrl_en  in  1  start pulse; sampled when not busy
key_len  in  2  key length: 0 = 128, 1 = 192, 2 = 256, 3 = reserved; sampled with start
key  in  MAX_KEY_BITS  cipher key, MSB-aligned (AES-128 uses the top 128 bits); sampled with start
round  in  4  requested round index, 0..Nr
round_key  out  128  words 4r..4r+3, word 4r in the MSBs, registered
key_ready  out  1  schedule complete and valid
busy  out  1  expansion in progress
round_err  out  1  registered flag: last request had round > Nr or was made while not ready

Behaviour:
- Reset (srst_n = 0 at a clock edge):
  - State goes to IDLE; round_key = 0, key_ready = 0, busy = 0, round_err = 0.
  - Word file contents become don't-care.
  - Reset has priority over start and aborts an expansion in progress.
- Per key length: Nk = 4/6/8, Nr = 10/12/14, total words W = 44/52/60.
- States: IDLE, EXPAND, DONE.
- IDLE or DONE, key_ctrl_en = 1, key_len legal:
  - At that edge, latch key_len.
  - Write words 0..Nk-1 from key.
  - Set pointer i = Nk, rcon = 0x01, position counter = 0.
  - Go to EXPAND; busy = 1, key_ready = 0.
- Illegal start is ignored with no state change. Illegal means key_len = 3, or key_len above MAX_KEY_BITS (for example 1 or 2 when MAX_KEY_BITS = 128).
- EXPAND writes one word per cycle: w[i] = w[i-Nk] ^ temp.
  - temp = SubWord(RotWord(w[i-1])) ^ {rcon, 24'h0} when position = 0.
  - temp = SubWord(w[i-1]) when Nk = 8 and position = 4.
  - temp = w[i-1] otherwise.
  - Position counter runs 0..Nk-1 and wraps; no modulo hardware.
  - rcon advances by xtime on each wrap. 0x80 -> 0x1B is produced naturally by xtime and must not be special-cased.
- Completion:
  - When word W-1 is written, go to DONE; key_ready = 1 and busy = 0 from the next cycle.
  - key_ready rises exactly W-Nk edges after the start edge: 40, 46 or 52.
- key_ctrl_en during EXPAND is ignored. key and key_len changes after start are ignored.
- Restart from DONE: key_ready falls at the start edge and the new schedule is expanded from scratch.
- Read port, evaluated every cycle:
  - If key_ready and round <= Nr: round_key = {w[4r], w[4r+1], w[4r+2], w[4r+3]} and round_err = 0, both at the next edge.
  - Otherwise: round_key = 0 and round_err = 1.
  - Read latency is 1 cycle, and back-to-back requests are supported.
- The word file has one write port and four read ports, and is register based.

Decomposition:
- aes_pkg holds:
  - key-length encoding constants;
  - functions returning Nk, Nr and W from key_len;
  - the xtime function;
  - the 256-entry S-box constant function;
  - the MAX_WORDS derivation from MAX_KEY_BITS.
- Sub-module aes_subword: combinational, 32-bit in/out, four S-box lookups from aes_pkg. Instantiated once in the expander; later reused by the cipher datapath.

Test Plan:
- AES-128, key 000102030405060708090a0b0c0d0e0f:
  - key_ready exactly 40 cycles after the start edge.
  - round 0 -> 000102030405060708090a0b0c0d0e0f.
  - round 10 -> 13111d7fe3944a17f307a78b4d2b30c5.
- AES-192, key 000102030405060708090a0b0c0d0e0f1011121314151617:
  - key_ready after 46 cycles.
  - round 1 -> 10111213141516175846f2f95c43f4fe.
  - round 12 -> a4970a331a78dc09c418c271e3a41d5d.
- AES-256, key 000102..1e1f:
  - key_ready after 52 cycles.
  - round 2 -> a573c29fa176c498a97fce93a572c09c.
  - round 14 -> 24fc79ccbf0979e9371ac23c6d68de36.
  - round 15 -> round_key 0, round_err = 1.
- AES-128, key 2b7e151628aed2a6abf7158809cf4f3c:
  - round 10 -> d014f9a8c9ee2589e13f0cc8b6630ca6.
  - Then sweep rounds 0..10 on consecutive cycles; each round key appears one cycle after its index.
- Reset and restart control:
  - Assert srst_n = 0 at cycle 20 of an AES-256 expansion -> key_ready and busy are 0 next cycle.
  - A fresh AES-128 start then completes in 40 cycles with correct keys.
  - key_ctrl_en pulsed mid-expansion has no effect on timing or keys.
- key_len = 3 with key_ctrl_en -> state unchanged: busy stays 0 and the previous schedule remains readable.
  - With MAX_KEY_BITS = 128, a start with key_len = 2 is likewise ignored.
